// File: rtl/key_debounce_bank.sv
// key_debounce_bank: multi-channel key synchroniser/debouncer with press and release pulses.
// Define KEY_AUTO_REPEAT_EN to add auto-repeat press pulses while a key is held.
module key_debounce_bank #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [NUM_KEYS-1:0] norm, sync1, sync2;
  assign norm = (ACTIVE_LOW != 0) ? ~key : key;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= norm;
      sync2 <= sync1;
    end
  genvar i;
  for (i = 0; i < NUM_KEYS; i++) begin : g_ch
    logic [CW-1:0] cnt;
    logic          ks, pp, rp, differ, accept;
    assign differ        = sync2[i] != ks;
    assign accept        = differ && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign key_state[i]     = ks;
    assign press_pulse[i]   = pp;
    assign release_pulse[i] = rp;
    always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
        cnt <= '0;
        ks  <= 1'b0;
        rp  <= 1'b0;
      end else begin
        cnt <= (!differ || accept) ? '0 : cnt + 1'b1;
        ks  <= accept ? sync2[i] : ks;
        rp  <= accept & ~sync2[i];
      end
`ifdef KEY_AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    logic [RW-1:0] rc;
    logic          ph, fire;
    // ph marks that the initial delay has elapsed and period spacing applies
    assign fire = ks && !accept && (ph ? (rc == RW'(REPEAT_PERIOD - 1)) : (rc == RW'(REPEAT_DELAY - 1)));
    always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
        rc <= '0;
        ph <= 1'b0;
        pp <= 1'b0;
      end else begin
        rc <= (!ks || accept || fire) ? '0 : rc + 1'b1;
        ph <= (!ks || accept) ? 1'b0 : (fire ? 1'b1 : ph);
        pp <= (accept & sync2[i]) | fire;
      end
`else
    always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) pp <= 1'b0;
      else pp <= accept & sync2[i];
`endif
  end
endmodule

// File: tb/tb_key_debounce_bank.sv
// tb_key_debounce_bank: randomized and directed checks of key_debounce_bank against a behavioural model.
module tb_key_debounce_bank;
  localparam int N  = 4;
  localparam int D  = 8;
  localparam int RD = 20;
  localparam int RP = 5;
  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] key = '0;
  logic [N-1:0] key_state, press_pulse, release_pulse;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  key_debounce_bank #(
    .NUM_KEYS(N), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clock(clock), .reset_n(reset_n), .key(key),
    .key_state(key_state), .press_pulse(press_pulse), .release_pulse(release_pulse)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  logic [N-1:0] m_s1, m_s2, m_state, m_pp, m_rp;
  int m_run [N];
  int m_age [N];
  // a level is accepted once sync2 has disagreed with the state for D consecutive edges
  function automatic bit acc(int i);
    return (m_s2[i] != m_state[i]) && (m_run[i] + 1 == D);
  endfunction
`ifdef KEY_AUTO_REPEAT_EN
  // repeats fall at RD, RD+RP, RD+2RP, ... edges after the initial press
  function automatic bit fire(int i);
    int a;
    a = m_age[i] + 1;
    return m_state[i] && !acc(i) && (a == RD || (a > RD && (a - RD) % RP == 0));
  endfunction
`endif
  always @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      m_s1    <= '0;
      m_s2    <= '0;
      m_state <= '0;
      m_pp    <= '0;
      m_rp    <= '0;
      m_run   <= '{default: 0};
      m_age   <= '{default: 0};
    end else begin
      m_s1 <= ~key;
      m_s2 <= m_s1;
      for (int i = 0; i < N; i++) begin
        m_run[i] <= (m_s2[i] == m_state[i] || acc(i)) ? 0 : m_run[i] + 1;
        m_state[i] <= acc(i) ? m_s2[i] : m_state[i];
`ifdef KEY_AUTO_REPEAT_EN
        m_pp[i] <= (acc(i) && m_s2[i]) || fire(i);
`else
        m_pp[i] <= acc(i) && m_s2[i];
`endif
        m_rp[i]  <= acc(i) && !m_s2[i];
        m_age[i] <= (acc(i) || !m_state[i]) ? 0 : m_age[i] + 1;
      end
    end
  always @(negedge clock) begin
    tests = tests + 1;
    if ({key_state, press_pulse, release_pulse} !== {m_state, m_pp, m_rp} || (press_pulse & release_pulse) != '0) begin
      fails = fails + 1;
      $display("FAIL model cyc=%0d state=%b/%b press=%b/%b release=%b/%b (dut/required)",
               cyc, key_state, m_state, press_pulse, m_pp, release_pulse, m_rp);
    end
  end
  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s cyc=%0d got=%b required=%b", name, cyc, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  initial begin
    int cnt;
    key = 4'b0000;
    tick(5);
    check("reset_state", key_state, 4'b0000);
    check("reset_press", press_pulse, 4'b0000);
    reset_n = 1'b1;
    tick(9);
    check("rst_press_early", press_pulse, 4'b0000);
    tick(1);
    check("rst_press_all", press_pulse, 4'b1111);
    tick(1);
    check("rst_press_one_cycle", press_pulse, 4'b0000);
    key = 4'b1111;
    tick(10);
    check("release_all", release_pulse, 4'b1111);
    tick(5);
    key[0] = 1'b0;
    tick(9);
    check("ch0_press_early", press_pulse, 4'b0000);
    tick(1);
    check("ch0_press", press_pulse, 4'b0001);
    tick(1);
    check("ch0_state", key_state, 4'b0001);
    key[0] = 1'b1;
    tick(12);
    cnt = 0;
    for (int t = 0; t < 24; t++) begin
      if (t % 3 == 0) key[1] = ~key[1];
      tick(1);
      cnt += press_pulse[1] + release_pulse[1];
    end
    key[1] = 1'b0;
    tick(9);
    cnt += press_pulse[1];
    check("bounce_quiet", 4'(cnt), 4'd0);
    tick(1);
    check("bounce_press", press_pulse, 4'b0010);
    key[1] = 1'b1;
    tick(12);
    cnt = 0;
    key[2] = 1'b0;
    tick(7);
    key[2] = 1'b1;
    for (int t = 0; t < 14; t++) begin
      tick(1);
      cnt += press_pulse[2] + key_state[2];
    end
    check("glitch7", 4'(cnt), 4'd0);
    key[2] = 1'b0;
    tick(8);
    key[2] = 1'b1;
    cnt = 0;
    for (int t = 0; t < 20; t++) begin
      tick(1);
      cnt += press_pulse[2] * 4 + release_pulse[2];
    end
    check("glitch8", 4'(cnt), 4'd5);
    key = 4'b0110;
    tick(10);
    check("pair_press", press_pulse, 4'b1001);
    tick(30);
    key = 4'b1111;
    tick(10);
    check("pair_release", release_pulse, 4'b1001);
    tick(5);
    key[2] = 1'b0;
    tick(5);
    reset_n = 1'b0;
    #1;
    check("async_reset", key_state | press_pulse, 4'b0000);
    tick(2);
    reset_n = 1'b1;
    tick(9);
    check("midreset_early", press_pulse, 4'b0000);
    tick(1);
    check("midreset_press", press_pulse, 4'b0100);
    key = 4'b1111;
    tick(12);
    for (int t = 0; t < 3000; t++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 9) == 0) key[b] = ~key[b];
      tick(1);
    end
    key = 4'b1111;
    tick(40);
`ifdef KEY_AUTO_REPEAT_EN
    key[0] = 1'b0;
    tick(10);
    check("rep_first", press_pulse, 4'b0001);
    cnt = 0;
    for (int t = 1; t <= 50; t++) begin
      tick(1);
      cnt += press_pulse[0];
      if (t == 20 || t == 25) check("rep_slot", press_pulse, 4'b0001);
      if (t == 19 || t == 21) check("rep_gap", press_pulse, 4'b0000);
    end
    check("rep_count", 4'(cnt), 4'd7);
    key[0] = 1'b1;
    tick(40);
    check("rep_stopped", key_state, 4'b0000);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/key_debounce_bank.md
Name: key_debounce_bank

Overview:
- Parametrised, multi-channel successor to the single-key press filter.
- Per channel:
  - 2-flop synchroniser, with polarity normalisation.
  - Counter-based debounce.
  - Registered one-cycle press and release pulses.
  - Debounced level output.
- Sits between the raw board push-buttons and the FSM/UI logic. Consumers see clean, single-cycle events per physical press.

Parameters:
- NUM_KEYS, 4: number of independent key channels, >= 1.
- DEBOUNCE_CYCLES, 50000: consecutive cycles a synchronised level must differ from the debounced state before it is accepted, >= 1.
- ACTIVE_LOW, 1: 1 means raw key low = pressed; 0 means raw key high = pressed.
- REPEAT_DELAY, 25000000: cycles from press pulse to first auto-repeat pulse. Used only with KEY_AUTO_REPEAT_EN.
- REPEAT_PERIOD, 5000000: cycles between subsequent auto-repeat pulses. Used only with KEY_AUTO_REPEAT_EN.

Ports:
- clock, input, 1: system clock; all state updates on rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- key, input, NUM_KEYS: raw asynchronous button inputs.
- key_state, output, NUM_KEYS: debounced level, 1 = pressed.
- press_pulse, output, NUM_KEYS: one-cycle pulse per accepted press (and per repeat when enabled).
- release_pulse, output, NUM_KEYS: one-cycle pulse per accepted release.

Behaviour:
- One clock; reset is asynchronous and active-low (reset_n). Reset asserts immediately and deasserts on a clock edge; no gated or derived clocks.
- Reset values, all channels:
  - sync stages 0 (logical, not pressed).
  - counters 0.
  - key_state 0.
  - press_pulse 0.
  - release_pulse 0.
  - repeat counter 0.
- Normalisation: logical key = ACTIVE_LOW ? ~key : key, applied before the synchroniser. Downstream logic is 1 = pressed.
- Synchroniser: two flops per channel. sync2 is the only signal used by the debounce logic.
- Debounce counter:
  - Width $clog2(DEBOUNCE_CYCLES+1).
  - If sync2 == key_state: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: key_state <= sync2, counter <= 0, and the matching pulse is registered high.
  - Else: counter <= counter+1.
- Pulses:
  - press_pulse[i] is high exactly on the cycle key_state[i] first reads 1.
  - release_pulse[i] is high exactly on the cycle key_state[i] first reads 0.
  - Each pulse lasts exactly one cycle; never high two consecutive cycles from debounce alone.
- Latency: a clean level change first sampled at edge k gives key_state/pulse visible after edge k+1+DEBOUNCE_CYCLES, i.e. DEBOUNCE_CYCLES+2 edges.
- Bounce and glitches:
  - Any return of sync2 to key_state before the count completes clears the counter.
  - Glitches shorter than DEBOUNCE_CYCLES produce no output change.
- Channels are fully independent. Simultaneous presses/releases on different channels pulse on the same cycle if their timings match.
- press_pulse and release_pulse on the same channel are never high together.
- Reset mid-count: counter and all state clear asynchronously. After release of reset, a held key requires a full DEBOUNCE_CYCLES+2 before press_pulse.

Optional Feature:
- Macro: KEY_AUTO_REPEAT_EN.
- Defined:
  - Per-channel repeat counter, width sized for max(REPEAT_DELAY, REPEAT_PERIOD).
  - Cleared on every press_pulse, and whenever key_state = 0.
  - While key_state = 1: first extra press_pulse occurs REPEAT_DELAY cycles after the initial press_pulse. Further pulses follow every REPEAT_PERIOD cycles.
  - Release stops repeats immediately; a repeat never coincides with release_pulse.
  - Reset clears the repeat counters.
- Undefined:
  - No repeat logic is synthesised; REPEAT_DELAY and REPEAT_PERIOD are ignored.
  - Exactly one press_pulse per accepted press.

Test Plan (NUM_KEYS=4, DEBOUNCE_CYCLES=8, ACTIVE_LOW=1):
1. Hold reset_n=0 for 5 cycles with key=4'b0000 (all pressed raw) -> all outputs 0 throughout reset. After release, press_pulse=4'b1111 for one cycle, 10 edges later.
2. Reset released, key=4'b1111, drive key[0]=0 at edge 20 and hold -> press_pulse[0]=1 for one cycle after edge 30; key_state[0]=1 from then on; other bits 0.
3. key[1] toggles every 3 cycles for 24 cycles, then held 0 -> exactly one press_pulse[1], 10 edges after the last toggle; no release_pulse.
4. key[2] low for 7 cycles then high -> no pulses; key_state[2] stays 0. Repeat with 8 cycles -> one press_pulse, then one release_pulse after the high level persists 8 cycles.
5. Channels 0 and 3 pressed on the same edge, released 40 cycles later -> press_pulse=4'b1001 on one cycle and release_pulse=4'b1001 on one cycle. Assert reset_n=0 mid-count on a third channel -> its counter clears and there is no pulse.
6. With KEY_AUTO_REPEAT_EN, REPEAT_DELAY=20, REPEAT_PERIOD=5, hold key[0] for 50 cycles past the first press_pulse -> press_pulse[0] at t0, t0+20, t0+25, ..., t0+50; release -> repeats stop and one release_pulse.
